// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the LSU controller and memory.
// Master issues req/we/addr/be/wdata; slave returns gnt/rvalid/rdata.
interface lsu_mem_ctrl_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// LSU data-memory sequencer: IDLE/REQ/WAIT over a req/gnt/rvalid bus.
// Optional bus timeout abort enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req_valid,
    input  logic        lsu_we,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [4:0]  lsu_rd_reg_addr,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic        lsu_misalign_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_reg_wdata_o,
    output logic        lsu_rd_reg_en_o,
    output logic [4:0]  lsu_rd_reg_addr_o,
    lsu_mem_ctrl_if.master dbus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [4:0]  rd_q;

    logic        done_q;
    logic        misal_q;
    logic        err_q;
    logic        rd_en_q;
    logic [31:0] reg_wdata_q;
    logic [4:0]  rd_addr_q;

    logic        misalign;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] ext;
    logic        complete;
    logic        tmo;

    assign misalign = ((lsu_size == 2'b01) & lsu_addr[0])
                    | (lsu_size[1] & (lsu_addr[1:0] != 2'b00));

    always_comb begin
        be_d    = 4'b0000;
        wdata_d = 32'h0;
        unique case (1'b1)
            lsu_size[1]: begin
                be_d    = 4'b1111;
                wdata_d = lsu_wdata;
            end
            (lsu_size == 2'b01): begin
                be_d    = 4'b0011 << lsu_addr[1:0];
                wdata_d = {2{lsu_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b0001 << lsu_addr[1:0];
                wdata_d = {4{lsu_wdata[7:0]}};
            end
        endcase
    end

    // Load data is lane-shifted down to bit 0 before extension.
    always_comb begin
        shifted = dbus.dbus_rdata >> {off_q, 3'b000};
        ext     = shifted;
        unique case (1'b1)
            size_q[1]: ext = shifted;
            (size_q == 2'b01):
                ext = uns_q ? {16'h0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
            default:
                ext = uns_q ? {24'h0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
        endcase
    end

    assign complete = ((state_q == REQ) & dbus.dbus_gnt & dbus.dbus_rvalid)
                    | ((state_q == WAIT) & dbus.dbus_rvalid);

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || state_q == IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tmo = (state_q != IDLE) & ~complete
               & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rd_q        <= 5'd0;
            done_q      <= 1'b0;
            misal_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            reg_wdata_q <= 32'h0;
            rd_addr_q   <= 5'd0;
        end else begin
            done_q  <= 1'b0;
            misal_q <= 1'b0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
            if (complete) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
                done_q  <= 1'b1;
                if (!we_q) begin
                    rd_en_q     <= (rd_q != 5'd0);
                    rd_addr_q   <= rd_q;
                    reg_wdata_q <= ext;
                end
            end else if (tmo) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (lsu_req_valid && misalign) begin
                            misal_q <= 1'b1;
                        end else if (lsu_req_valid) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= lsu_we;
                            addr_q  <= {lsu_addr[31:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            off_q   <= lsu_addr[1:0];
                            size_q  <= lsu_size;
                            uns_q   <= lsu_unsigned;
                            rd_q    <= lsu_rd_reg_addr;
                        end
                    end
                    REQ: begin
                        if (dbus.dbus_gnt) begin
                            state_q <= WAIT;
                            req_q   <= 1'b0;
                        end
                    end
                    WAIT: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign lsu_busy_o = (state_q != IDLE) | (lsu_req_valid & ~misalign);

    assign lsu_done_o        = done_q;
    assign lsu_misalign_o    = misal_q;
    assign lsu_err_o         = err_q;
    assign lsu_reg_wdata_o   = reg_wdata_q;
    assign lsu_rd_reg_en_o   = rd_en_q;
    assign lsu_rd_reg_addr_o = rd_addr_q;

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_be    = be_q;
    assign dbus.dbus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases then random accesses
// checked against an arithmetic model of the access rules.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_we = 1'b0;
    logic [1:0]  lsu_size = 2'b00;
    logic        lsu_unsigned = 1'b0;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wdata = 32'h0;
    logic [4:0]  lsu_rd_reg_addr = 5'd0;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic        lsu_misalign_o;
    logic        lsu_err_o;
    logic [31:0] lsu_reg_wdata_o;
    logic        lsu_rd_reg_en_o;
    logic [4:0]  lsu_rd_reg_addr_o;

    int total = 0;
    int bad = 0;

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lsu_req_valid     (lsu_req_valid),
        .lsu_we            (lsu_we),
        .lsu_size          (lsu_size),
        .lsu_unsigned      (lsu_unsigned),
        .lsu_addr          (lsu_addr),
        .lsu_wdata         (lsu_wdata),
        .lsu_rd_reg_addr   (lsu_rd_reg_addr),
        .lsu_busy_o        (lsu_busy_o),
        .lsu_done_o        (lsu_done_o),
        .lsu_misalign_o    (lsu_misalign_o),
        .lsu_err_o         (lsu_err_o),
        .lsu_reg_wdata_o   (lsu_reg_wdata_o),
        .lsu_rd_reg_en_o   (lsu_rd_reg_en_o),
        .lsu_rd_reg_addr_o (lsu_rd_reg_addr_o),
        .dbus              (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_misal(input logic [1:0] size,
                                    input logic [31:0] addr);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size,
                                       input logic [31:0] addr);
        int s = 0;
        int off = int'(addr % 4);
        for (int i = 0; i < nbytes(size); i++) s += 1 << (off + i);
        return s[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size,
                                            input logic [31:0] wd);
        int n = nbytes(size);
        if (n == 1) return (wd % 256) * 32'h01010101;
        if (n == 2) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size,
                                           input logic uns,
                                           input logic [31:0] addr,
                                           input logic [31:0] rdata);
        longint v;
        longint range;
        int n = nbytes(size);
        if (n == 4) return rdata;
        range = longint'(1) << (8 * n);
        v = (longint'(rdata) / (longint'(1) << (8 * (addr % 4)))) % range;
        if (!uns && v >= range / 2) v = v - range;
        return v[31:0];
    endfunction

    // gd: cycles before gnt; rvd: cycles from gnt to rvalid (0 = same cycle)
    task automatic access(input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input int gd, input int rvd,
                          input logic [31:0] rdata);
        bit mis = is_misal(size, addr);
        lsu_req_valid = 1'b1;
        lsu_we = we;
        lsu_size = size;
        lsu_unsigned = uns;
        lsu_addr = addr;
        lsu_wdata = wd;
        lsu_rd_reg_addr = rd;
        #1;
        chk("busy_accept", {31'd0, lsu_busy_o}, {31'd0, !mis});
        step();
        lsu_req_valid = 1'b0;
        lsu_addr = $urandom;
        lsu_wdata = $urandom;
        if (mis) begin
            chk("misal_pulse", {31'd0, lsu_misalign_o}, 32'd1);
            chk("misal_noreq", {31'd0, bus.dbus_req}, 32'd0);
            chk("misal_busy", {31'd0, lsu_busy_o}, 32'd0);
            step();
            chk("misal_end", {31'd0, lsu_misalign_o}, 32'd0);
            chk("misal_noreq2", {31'd0, bus.dbus_req}, 32'd0);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            chk("req_hi", {31'd0, bus.dbus_req}, 32'd1);
            chk("req_we", {31'd0, bus.dbus_we}, {31'd0, we});
            chk("req_addr", bus.dbus_addr, addr & 32'hFFFF_FFFC);
            chk("req_be", {28'd0, bus.dbus_be}, {28'd0, m_be(size, addr)});
            if (we) chk("req_wdata", bus.dbus_wdata, m_wdata(size, wd));
            chk("req_busy", {31'd0, lsu_busy_o}, 32'd1);
            chk("req_nodone", {31'd0, lsu_done_o}, 32'd0);
            bus.dbus_rvalid = (i == 0 && gd > 0);
            bus.dbus_rdata = $urandom;
            if (i == gd) begin
                bus.dbus_gnt = 1'b1;
                if (rvd == 0) begin
                    bus.dbus_rvalid = 1'b1;
                    bus.dbus_rdata = rdata;
                end
            end
            step();
        end
        bus.dbus_gnt = 1'b0;
        bus.dbus_rvalid = 1'b0;
        for (int i = 1; i <= rvd; i++) begin
            chk("wait_req_lo", {31'd0, bus.dbus_req}, 32'd0);
            chk("wait_busy", {31'd0, lsu_busy_o}, 32'd1);
            chk("wait_nodone", {31'd0, lsu_done_o}, 32'd0);
            if (i == rvd) begin
                bus.dbus_rvalid = 1'b1;
                bus.dbus_rdata = rdata;
            end
            step();
        end
        bus.dbus_rvalid = 1'b0;
        chk("done", {31'd0, lsu_done_o}, 32'd1);
        chk("done_req_lo", {31'd0, bus.dbus_req}, 32'd0);
        chk("done_busy", {31'd0, lsu_busy_o}, 32'd0);
        chk("err_lo", {31'd0, lsu_err_o}, 32'd0);
        chk("rd_en", {31'd0, lsu_rd_reg_en_o}, {31'd0, !we && rd != 0});
        if (!we) begin
            chk("rd_addr", {27'd0, lsu_rd_reg_addr_o}, {27'd0, rd});
            chk("ld_data", lsu_reg_wdata_o, m_load(size, uns, addr, rdata));
        end
        step();
        chk("done_end", {31'd0, lsu_done_o}, 32'd0);
        chk("rd_en_end", {31'd0, lsu_rd_reg_en_o}, 32'd0);
    endtask

    initial begin
        int n;
        bus.dbus_gnt = 1'b0;
        bus.dbus_rvalid = 1'b0;
        bus.dbus_rdata = 32'h0;
        repeat (3) step();
        chk("rst_req", {31'd0, bus.dbus_req}, 32'd0);
        chk("rst_done", {31'd0, lsu_done_o}, 32'd0);
        chk("rst_busy", {31'd0, lsu_busy_o}, 32'd0);
        chk("rst_wdata", lsu_reg_wdata_o, 32'd0);
        chk("rst_rd", {27'd0, lsu_rd_reg_addr_o}, 32'd0);
        rst_n = 1'b1;
        step();

        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata = 32'hDEAD_BEEF;
        step();
        bus.dbus_rvalid = 1'b0;
        chk("idle_rvalid_ign", {31'd0, lsu_done_o}, 32'd0);

        access(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 5'd5, 0, 0, 32'h8012_3456);
        chk("lb_lit", lsu_reg_wdata_o, 32'hFFFF_FF80);
        access(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 5'd6, 0, 1, 32'hABCD_1234);
        chk("lhu_lit", lsu_reg_wdata_o, 32'h0000_ABCD);
        access(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 5'd7, 1, 1, 32'hABCD_1234);
        chk("lh_lit", lsu_reg_wdata_o, 32'hFFFF_ABCD);
        access(1'b1, 2'b00, 1'b0, 32'h3001, 32'h5A, 5'd0, 0, 1, 32'h0);
        chk("sb_be_lit", {28'd0, bus.dbus_be}, 32'h2);
        chk("sb_wd_lit", bus.dbus_wdata, 32'h5A5A_5A5A);
        access(1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 5'd8, 0, 0, 32'h0);
        access(1'b1, 2'b10, 1'b0, 32'h5000, 32'h1234_5678, 5'd0, 3, 2, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h6004, 32'h0, 5'd0, 0, 0, 32'hCAFE_F00D);

        lsu_req_valid = 1'b1;
        lsu_we = 1'b0;
        lsu_size = 2'b10;
        lsu_addr = 32'h7000;
        lsu_rd_reg_addr = 5'd9;
        step();
        lsu_req_valid = 1'b0;
        bus.dbus_gnt = 1'b1;
        step();
        bus.dbus_gnt = 1'b0;
        chk("rst_mid_wait_busy", {31'd0, lsu_busy_o}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_busy", {31'd0, lsu_busy_o}, 32'd0);
        chk("rst_mid_req", {31'd0, bus.dbus_req}, 32'd0);
        chk("rst_mid_done", {31'd0, lsu_done_o}, 32'd0);
        bus.dbus_rvalid = 1'b1;
        step();
        bus.dbus_rvalid = 1'b0;
        chk("rst_mid_nodone", {31'd0, lsu_done_o}, 32'd0);
        chk("rst_mid_noen", {31'd0, lsu_rd_reg_en_o}, 32'd0);

        lsu_req_valid = 1'b1;
        lsu_we = 1'b1;
        lsu_size = 2'b10;
        lsu_addr = 32'h8000;
        step();
        lsu_req_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (lsu_err_o || lsu_done_o) begin
                n = i;
                break;
            end
        end
`ifdef LSU_TIMEOUT_EN
        chk("tmo_cycle", n, 16);
        chk("tmo_done", {31'd0, lsu_done_o}, 32'd1);
        chk("tmo_req_lo", {31'd0, bus.dbus_req}, 32'd0);
        chk("tmo_noen", {31'd0, lsu_rd_reg_en_o}, 32'd0);
        step();
        chk("tmo_err_end", {31'd0, lsu_err_o}, 32'd0);
`else
        chk("notmo_none", n, 0);
        chk("notmo_req", {31'd0, bus.dbus_req}, 32'd1);
        bus.dbus_gnt = 1'b1;
        bus.dbus_rvalid = 1'b1;
        step();
        bus.dbus_gnt = 1'b0;
        bus.dbus_rvalid = 1'b0;
        chk("notmo_done", {31'd0, lsu_done_o}, 32'd1);
        chk("notmo_err", {31'd0, lsu_err_o}, 32'd0);
        step();
`endif

        for (int k = 0; k < 60; k++) begin
            access(1'($urandom), 2'($urandom), 1'($urandom), $urandom,
                   $urandom, 5'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
